mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//
// Iterative multiply/divide unit for the MIPS core. Runs MULT/MULTU through a
// radix-2 shift-add multiplier and DIV/DIVU through a restoring divider, one
// iteration per clock for 32 clocks, followed by one sign-fixup clock. Owns
// the architectural HI/LO registers and services MTHI/MTLO directly.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous active-high reset (aborts an operation)
//   start  in   1   operation request, sampled only while busy = 0
//   op     in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                   100 MTHI, 101 MTLO, 110/111 no-op
//   A      in  32   rs operand (multiplicand / dividend / MTHI-MTLO data)
//   B      in  32   rt operand (multiplier / divisor)
//   busy   out  1   mult/div in progress (RUN or FIX)
//   done   out  1   one-cycle pulse: HI/LO were just written by mult/div
//   HI     out 32   HI register
//   LO     out 32   LO register
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t      state_q,  state_d;
    logic [5:0]  cnt_q,    cnt_d;
    logic [31:0] opa_q,    opa_d;     // multiplicand / dividend magnitude
    logic [31:0] opb_q,    opb_d;     // multiplier / divisor magnitude
    logic [31:0] work_hi_q, work_hi_d; // mult accumulator / div remainder
    logic [31:0] work_lo_q, work_lo_d; // mult multiplier / div quotient
    logic        is_div_q, is_div_d;
    logic        sign_p_q, sign_p_d;  // negate product / quotient
    logic        sign_r_q, sign_r_d;  // negate remainder
    logic [31:0] hi_q,     hi_d;
    logic [31:0] lo_q,     lo_d;
    logic        done_q,   done_d;

    // Operand conditioning at accept time. Signed ops work on magnitudes;
    // |0x80000000| wraps to 0x80000000, which is correct read as unsigned.
    logic        op_signed;
    logic [31:0] a_lat;
    logic [31:0] b_lat;

    assign op_signed = ~op[0];
    assign a_lat     = (op_signed && A[31]) ? (32'd0 - A) : A;
    assign b_lat     = (op_signed && B[31]) ? (32'd0 - B) : B;

    // Multiply step: add multiplicand when the multiplier LSB is set, then the
    // 64-bit {acc, mplier} pair shifts right with the carry entering acc MSB.
    logic [32:0] add_sum;
    assign add_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opa_q} : 33'd0);

    // Divide step: shift {rem, quot} left, trial-subtract the divisor from the
    // 33-bit partial remainder. When the trial succeeds the true difference is
    // below the divisor, so the low 32 bits of a 32-bit subtract are exact.
    logic [32:0] rem_sh;
    logic        trial_ok;
    logic [31:0] rem_sub;
    assign rem_sh   = {work_hi_q, work_lo_q[31]};
    assign trial_ok = (rem_sh >= {1'b0, opb_q});
    assign rem_sub  = rem_sh[31:0] - opb_q;

    logic [63:0] product;
    assign product = {work_hi_q, work_lo_q};

    // NOTE: every signal written below gets its default first, so no path
    // through the case/if tree leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        is_div_d  = is_div_q;
        sign_p_d  = sign_p_q;
        sign_r_d  = sign_r_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            opa_d     = a_lat;
                            opb_d     = b_lat;
                            sign_p_d  = op_signed & (A[31] ^ B[31]);
                            sign_r_d  = op_signed & A[31];
                            is_div_d  = op[1];
                            work_hi_d = 32'd0;
                            work_lo_d = op[1] ? a_lat : b_lat;
                            cnt_d     = 6'd32;
                            state_d   = S_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end

            S_RUN: begin
                if (is_div_q) begin
                    work_hi_d = trial_ok ? rem_sub : rem_sh[31:0];
                    work_lo_d = {work_lo_q[30:0], trial_ok};
                end else begin
                    work_hi_d = add_sum[32:1];
                    work_lo_d = {add_sum[0], work_lo_q[31:1]};
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (is_div_q) begin
                    if (opb_q == 32'd0) begin
                        lo_d = DIVZERO_LO;
                        hi_d = opa_q;
                    end else begin
                        lo_d = sign_p_q ? (32'd0 - work_lo_q) : work_lo_q;
                        hi_d = sign_r_q ? (32'd0 - work_hi_q) : work_hi_q;
                    end
                end else begin
                    {hi_d, lo_d} = sign_p_q ? (64'd0 - product) : product;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            work_hi_q <= 32'd0;
            work_lo_q <= 32'd0;
            is_div_q  <= 1'b0;
            sign_p_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            is_div_q  <= is_div_d;
            sign_p_q  <= sign_p_d;
            sign_r_q  <= sign_r_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
//
// Directed self-checking bench for mdu_ctrl. Expected HI/LO values are
// hand-computed constants; latency and busy length are counted against 33.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int pass_cnt  = 0;
    int check_cnt = 0;

    mdu_ctrl #(.DIVZERO_LO(32'hFFFF_FFFF)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op_i),
        .A     (a_i),
        .B     (b_i),
        .busy  (busy),
        .done  (done),
        .HI    (hi_o),
        .LO    (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue a mult/div at edge E0, wait (bounded) for done, and check latency,
    // busy length and the final HI/LO. With inject set, an MTHI and a second
    // MULTU are presented mid-operation and must have no effect.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit inject);
        int n;
        int bcnt;
        logic [31:0] hi_before;
        hi_before = hi_o;
        @(negedge clk);
        start = 1'b1;
        op_i  = op;
        a_i   = a;
        b_i   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_i   = $urandom;
        b_i   = $urandom;
        check({tag, " busy_e0"}, {63'd0, busy}, 64'd1);
        n    = 0;
        bcnt = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bcnt++;
            if (inject) begin
                if (n == 3) begin
                    start = 1'b1;
                    op_i  = 3'b100;
                    a_i   = 32'h1234_5678;
                end else if (n == 4) begin
                    op_i = 3'b001;
                    a_i  = 32'd2;
                    b_i  = 32'd3;
                end else if (n == 5) begin
                    start = 1'b0;
                end else if (n == 8) begin
                    check({tag, " hi_held"}, {32'd0, hi_o}, {32'd0, hi_before});
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " busy_len"}, 64'(bcnt), 64'd33);
        check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
        check({tag, " HI"}, {32'd0, hi_o}, {32'd0, exp_hi});
        check({tag, " LO"}, {32'd0, lo_o}, {32'd0, exp_lo});
    endtask

    // Single-edge IDLE request (MTHI/MTLO/no-op).
    task automatic idle_op(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1;
        op_i  = op;
        a_i   = a;
        b_i   = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int dcnt;
        rst   = 1'b1;
        start = 1'b0;
        op_i  = 3'b000;
        a_i   = 32'd0;
        b_i   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        check("rst HI", {32'd0, hi_o}, 64'd0);
        check("rst LO", {32'd0, lo_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: MULTU max * max, done is a single-cycle pulse
        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(posedge clk);
        #1;
        check("multu_max done_pulse", {63'd0, done}, 64'd0);

        // 2: signed multiplies
        run_op("mult_neg", 3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("mult_min", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);

        // 3: signed/unsigned divide of the same operands; started back-to-back
        // in the done cycle of the previous op
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu", 3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);

        // 4: overflow case and divide by zero
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_zero", 3'b011, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0);

        // 5: requests during busy are ignored
        run_op("multu_inj", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        @(posedge clk);
        #1;
        check("inj no_restart busy", {63'd0, busy}, 64'd0);
        check("inj no_restart done", {63'd0, done}, 64'd0);

        idle_op(3'b101, 32'hCAFE_BABE);
        check("mtlo LO", {32'd0, lo_o}, {32'd0, 32'hCAFE_BABE});
        check("mtlo HI kept", {32'd0, hi_o}, {32'd0, 32'hFFFF_FFFE});
        check("mtlo busy", {63'd0, busy}, 64'd0);
        check("mtlo done", {63'd0, done}, 64'd0);

        idle_op(3'b100, 32'hDEAD_BEEF);
        check("mthi HI", {32'd0, hi_o}, {32'd0, 32'hDEAD_BEEF});
        check("mthi busy", {63'd0, busy}, 64'd0);

        idle_op(3'b110, 32'h1111_1111);
        check("noop HI", {32'd0, hi_o}, {32'd0, 32'hDEAD_BEEF});
        check("noop LO", {32'd0, lo_o}, {32'd0, 32'hCAFE_BABE});
        check("noop busy", {63'd0, busy}, 64'd0);

        // 6: reset in the 10th RUN cycle aborts without a done pulse
        @(negedge clk);
        start = 1'b1;
        op_i  = 3'b011;
        a_i   = 32'd100;
        b_i   = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort HI", {32'd0, hi_o}, 64'd0);
        check("abort LO", {32'd0, lo_o}, 64'd0);
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        check("abort no_done", 64'(dcnt), 64'd0);

        run_op("divu_after_rst", 3'b011, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
